mem_wb_inst1_stage: RTL and testbench
=====================================

# mem_wb_inst1_stage

Memory-access stage plus MEM/WB pipeline register for the instruction-1 lane of the dual-issue core. It consumes the EX/MEM lane-1 register outputs (ALU result, store data, destination register, PC, control), performs the data-memory load or store, and selects the writeback value. It registers the result into MEM/WB state that drives register-file writeback and the forwarding network.

## Interface
- DATA_W, 32, data word width
- ADDR_W, 8, word-address width; memory depth is 2^ADDR_W words
- PC_W, 8, program-counter width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold all MEM/WB outputs and suppress the memory write this cycle
- flush  in  1  insert a bubble into MEM/WB; lower priority than stall
- AluOutMem  in  DATA_W  ALU result; bits [ADDR_W-1:0] are the word address
- ReadData2Mem  in  DATA_W  store data
- dest_reg_Mem  in  5  destination register
- pcM  in  PC_W  PC of the instruction in MEM
- MemReadEn_Mem, MemWriteEn_Mem, RegWriteEn_Mem  in  1 each  control
- MemtoReg_Mem  in  2  writeback select
- WBData  out  DATA_W  registered writeback value
- dest_reg_WB  out  5  registered destination register
- RegWriteEn_WB  out  1  registered write enable; forced 0 when dest_reg_WB==0
- pcW  out  PC_W  registered PC, for debug and trace
- load_valid_WB  out  1  the instruction now in WB was a load

## Operation
- Memory: DATA_W x 2^ADDR_W array, single port, word addressed. Address bits above ADDR_W-1 are ignored, so the address wraps.
- Memory contents are not cleared by reset.
- Store: the array is written at the rising edge when MemWriteEn_Mem=1 and stall=0. flush does not block a store already in MEM.
- Load: asynchronous array read at the address. The read value is captured into WBData at the same edge.
- If MemReadEn_Mem and MemWriteEn_Mem are both 1, the store is performed. The load returns the old word.
- Writeback select, computed before the register:
  - 00: AluOutMem
  - 01: memory word if MemReadEn_Mem=1, else AluOutMem
  - 10: zero-extended pcM+1, the link value; the PC_W addition wraps
  - 11: AluOutMem
- MEM/WB register update, in priority order:
  - reset: all outputs 0
  - stall: all outputs hold
  - flush: RegWriteEn_WB=0, load_valid_WB=0, dest_reg_WB=0, WBData=0, pcW=pcM
  - otherwise: load the selected values
- RegWriteEn_WB is registered as RegWriteEn_Mem && (dest_reg_Mem!=0).
- load_valid_WB is registered as MemReadEn_Mem && MemtoReg_Mem==01.

## Timing
- Latency: one cycle from MEM inputs to WB outputs. A store takes effect in the array at the same edge.
- Store followed by a load to the same address in the next cycle returns the new data. No internal bypass is required.
- Reset is asynchronous. Assertion immediately clears every output, regardless of clk. Memory is untouched.
- Reset asserted mid-store: a write whose edge coincides with reset assertion is not guaranteed. The bench must not check it.
- On deassertion, the first capture happens at the next rising edge.
- stall and flush together: stall wins and outputs hold.
- Write-enable gating by stall is combinational on the current-cycle stall.

## Test plan
- Reset: drive nonzero inputs, assert reset between edges. All outputs go to 0 immediately and stay 0 while reset is high.
- Store then load: store 0xDEADBEEF to addr 0x05, then load addr 0x05 with MemtoReg=01 and dest=7. At the second edge WBData=0xDEADBEEF, dest_reg_WB=7, RegWriteEn_WB=1, load_valid_WB=1.
- Address wrap: store 0x12345678 with AluOutMem=0x00000105, then load with AluOutMem=0x00000005. The load returns 0x12345678.
- Link and zero register:
  - MemtoReg=10, pcM=0xFF: WBData=0x00000000.
  - RegWriteEn=1, dest=0: RegWriteEn_WB=0.
- Stall and flush: with a store pending, hold stall=1 and flush=1 for 2 cycles. Outputs are unchanged and the memory word is unchanged. Then apply flush alone: RegWriteEn_WB=0, WBData=0, pcW=pcM.
- Read and write together: MemRead and MemWrite both 1, address 0x10 holding 0xA, store data 0xB. WBData=0xA, and a subsequent load returns 0xB.

Source files
------------

// File: rtl/mem_wb_inst1_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_inst1_stage_if
//  Purpose  : Bundles the lane-1 EX/MEM register outputs, the pipeline
//             control (stall/flush) and the MEM/WB register outputs.
//  Ports    : master - upstream pipeline / driver side
//             slave  - the MEM stage itself (consumes MEM, drives WB)
//  Revision : 1.0  initial release
// ============================================================================
interface mem_wb_inst1_stage_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 8
);
  // Pipeline control
  logic              stall;
  logic              flush;
  // EX/MEM register outputs
  logic [DATA_W-1:0] AluOutMem;
  logic [DATA_W-1:0] ReadData2Mem;
  logic [4:0]        dest_reg_Mem;
  logic [PC_W-1:0]   pcM;
  logic              MemReadEn_Mem;
  logic              MemWriteEn_Mem;
  logic              RegWriteEn_Mem;
  logic [1:0]        MemtoReg_Mem;
  // MEM/WB register outputs
  logic [DATA_W-1:0] WBData;
  logic [4:0]        dest_reg_WB;
  logic              RegWriteEn_WB;
  logic [PC_W-1:0]   pcW;
  logic              load_valid_WB;

  modport master (
    output stall, flush, AluOutMem, ReadData2Mem, dest_reg_Mem, pcM,
           MemReadEn_Mem, MemWriteEn_Mem, RegWriteEn_Mem, MemtoReg_Mem,
    input  WBData, dest_reg_WB, RegWriteEn_WB, pcW, load_valid_WB
  );

  modport slave (
    input  stall, flush, AluOutMem, ReadData2Mem, dest_reg_Mem, pcM,
           MemReadEn_Mem, MemWriteEn_Mem, RegWriteEn_Mem, MemtoReg_Mem,
    output WBData, dest_reg_WB, RegWriteEn_WB, pcW, load_valid_WB
  );
endinterface
`default_nettype wire

// File: rtl/mem_wb_inst1_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_inst1_stage
//  Purpose  : Lane-1 memory-access stage plus MEM/WB pipeline register.
//             Performs the data-memory load/store, selects the writeback
//             value and registers it for register-file writeback and
//             forwarding.
//  Ports    : clk   - rising-edge clock
//             reset - asynchronous active-high reset (clears WB outputs)
//             bus   - slave modport: MEM-stage inputs, stall/flush, WB outputs
//  Revision : 1.0  initial release
// ============================================================================
module mem_wb_inst1_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int PC_W   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_wb_inst1_stage_if.slave     bus
);

  localparam int DEPTH = 1 << ADDR_W;

  // Data memory: not reset, so contents survive a pipeline reset.
  logic [DATA_W-1:0] mem_array [0:DEPTH-1];

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] read_word;
  logic [PC_W-1:0]   pc_link;
  logic [DATA_W-1:0] wb_sel;
  logic              reg_write_sel;
  logic              load_valid_sel;

  logic [DATA_W-1:0] wb_data_reg;
  logic [4:0]        dest_reg_reg;
  logic              reg_write_reg;
  logic [PC_W-1:0]   pc_reg;
  logic              load_valid_reg;

  // Upper address bits are dropped so the address wraps around the array.
  assign mem_addr  = bus.AluOutMem[ADDR_W-1:0];
  assign read_word = mem_array[mem_addr];

  // Store is gated only by the current-cycle stall; a flush arriving behind
  // a store must not cancel it. On a simultaneous load+store the read above
  // sees the old word, since the array updates at the edge.
  always_ff @(posedge clk) begin
    if (bus.MemWriteEn_Mem && !bus.stall) begin
      mem_array[mem_addr] <= bus.ReadData2Mem;
    end
  end

  // Link value; the PC_W-wide sum wraps before zero extension.
  assign pc_link = bus.pcM + PC_W'(1);

  always_comb begin
    wb_sel = bus.AluOutMem;
    case (bus.MemtoReg_Mem)
      2'b01:   wb_sel = bus.MemReadEn_Mem ? read_word : bus.AluOutMem;
      2'b10:   wb_sel = {{(DATA_W-PC_W){1'b0}}, pc_link};
      default: wb_sel = bus.AluOutMem;
    endcase
  end

  // Writes to x0 are squashed here so downstream logic never sees them.
  assign reg_write_sel  = bus.RegWriteEn_Mem && (bus.dest_reg_Mem != 5'd0);
  assign load_valid_sel = bus.MemReadEn_Mem && (bus.MemtoReg_Mem == 2'b01);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_data_reg    <= '0;
      dest_reg_reg   <= '0;
      reg_write_reg  <= 1'b0;
      pc_reg         <= '0;
      load_valid_reg <= 1'b0;
    end else if (bus.stall) begin
      wb_data_reg    <= wb_data_reg;
      dest_reg_reg   <= dest_reg_reg;
      reg_write_reg  <= reg_write_reg;
      pc_reg         <= pc_reg;
      load_valid_reg <= load_valid_reg;
    end else if (bus.flush) begin
      // Bubble keeps the PC so trace still shows where the slot came from.
      wb_data_reg    <= '0;
      dest_reg_reg   <= '0;
      reg_write_reg  <= 1'b0;
      pc_reg         <= bus.pcM;
      load_valid_reg <= 1'b0;
    end else begin
      wb_data_reg    <= wb_sel;
      dest_reg_reg   <= bus.dest_reg_Mem;
      reg_write_reg  <= reg_write_sel;
      pc_reg         <= bus.pcM;
      load_valid_reg <= load_valid_sel;
    end
  end

  assign bus.WBData        = wb_data_reg;
  assign bus.dest_reg_WB   = dest_reg_reg;
  assign bus.RegWriteEn_WB = reg_write_reg;
  assign bus.pcW           = pc_reg;
  assign bus.load_valid_WB = load_valid_reg;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_inst1_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_wb_inst1_stage
//  Purpose  : Directed-vector bench for mem_wb_inst1_stage with a queue
//             scoreboard and an independent output monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_wb_inst1_stage;

  logic clk;
  logic reset;

  mem_wb_inst1_stage_if #(.DATA_W(32), .PC_W(8)) bus ();

  mem_wb_inst1_stage #(.DATA_W(32), .ADDR_W(8), .PC_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dest;
    logic        rwe;
    logic [7:0]  pc;
    logic        lv;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   vec_id = 0;

  // Monitor: the registered outputs are valid after every rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (bus.WBData !== e.data || bus.dest_reg_WB !== e.dest ||
          bus.RegWriteEn_WB !== e.rwe || bus.pcW !== e.pc ||
          bus.load_valid_WB !== e.lv) begin
        n_fail++;
        $display("FAIL vec%0d: got data=%h dest=%0d rwe=%b pc=%h lv=%b, want data=%h dest=%0d rwe=%b pc=%h lv=%b",
                 e.id, bus.WBData, bus.dest_reg_WB, bus.RegWriteEn_WB, bus.pcW,
                 bus.load_valid_WB, e.data, e.dest, e.rwe, e.pc, e.lv);
      end
    end
  end

  task automatic apply(
    input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] dst,
    input logic [7:0] pc, input logic mr, input logic mw, input logic rw,
    input logic [1:0] m2r, input logic st, input logic fl,
    input logic [31:0] e_data, input logic [4:0] e_dest, input logic e_rwe,
    input logic [7:0] e_pc, input logic e_lv);
    exp_t e;
    @(negedge clk);
    bus.AluOutMem      = alu;
    bus.ReadData2Mem   = sd;
    bus.dest_reg_Mem   = dst;
    bus.pcM            = pc;
    bus.MemReadEn_Mem  = mr;
    bus.MemWriteEn_Mem = mw;
    bus.RegWriteEn_Mem = rw;
    bus.MemtoReg_Mem   = m2r;
    bus.stall          = st;
    bus.flush          = fl;
    e.data = e_data; e.dest = e_dest; e.rwe = e_rwe;
    e.pc = e_pc; e.lv = e_lv; e.id = vec_id;
    vec_id++;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input int tag);
    n_vec++;
    if (bus.WBData !== 32'd0 || bus.dest_reg_WB !== 5'd0 ||
        bus.RegWriteEn_WB !== 1'b0 || bus.pcW !== 8'd0 ||
        bus.load_valid_WB !== 1'b0) begin
      n_fail++;
      $display("FAIL reset%0d: got data=%h dest=%0d rwe=%b pc=%h lv=%b, want all zero",
               tag, bus.WBData, bus.dest_reg_WB, bus.RegWriteEn_WB, bus.pcW,
               bus.load_valid_WB);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.AluOutMem = '0; bus.ReadData2Mem = '0; bus.dest_reg_Mem = '0;
    bus.pcM = '0; bus.MemReadEn_Mem = 1'b0; bus.MemWriteEn_Mem = 1'b0;
    bus.RegWriteEn_Mem = 1'b0; bus.MemtoReg_Mem = 2'b00;
    bus.stall = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_zero(0);
    @(negedge clk);
    reset = 1'b0;

    // Nonzero capture, then asynchronous reset between edges.
    //     alu           sd            dst    pc     mr mw rw m2r    st fl  exp
    apply(32'h55,        32'h0,        5'd3,  8'h20, 0, 0, 1, 2'b00, 0, 0, 32'h55, 5'd3, 1, 8'h20, 0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check_zero(1);
    @(posedge clk); #2;
    check_zero(2);
    @(negedge clk);
    reset = 1'b0;

    // Store then load.
    apply(32'h05,        32'hDEADBEEF, 5'd0,  8'h10, 0, 1, 0, 2'b00, 0, 0, 32'h05, 5'd0, 0, 8'h10, 0);
    apply(32'h05,        32'h0,        5'd7,  8'h11, 1, 0, 1, 2'b01, 0, 0, 32'hDEADBEEF, 5'd7, 1, 8'h11, 1);
    // Address wrap: 0x105 aliases 0x05.
    apply(32'h105,       32'h12345678, 5'd0,  8'h12, 0, 1, 0, 2'b00, 0, 0, 32'h105, 5'd0, 0, 8'h12, 0);
    apply(32'h05,        32'h0,        5'd8,  8'h13, 1, 0, 1, 2'b01, 0, 0, 32'h12345678, 5'd8, 1, 8'h13, 1);
    // Link value wraps; non-wrapping link.
    apply(32'h999,       32'h0,        5'd31, 8'hFF, 0, 0, 1, 2'b10, 0, 0, 32'h0, 5'd31, 1, 8'hFF, 0);
    apply(32'h999,       32'h0,        5'd31, 8'h3C, 0, 0, 1, 2'b10, 0, 0, 32'h3D, 5'd31, 1, 8'h3C, 0);
    // Write to x0 is squashed.
    apply(32'h77,        32'h0,        5'd0,  8'h20, 0, 0, 1, 2'b00, 0, 0, 32'h77, 5'd0, 0, 8'h20, 0);
    // MemtoReg=01 without MemRead selects ALU; MemtoReg=11 selects ALU.
    apply(32'h05,        32'h0,        5'd9,  8'h21, 0, 0, 1, 2'b01, 0, 0, 32'h05, 5'd9, 1, 8'h21, 0);
    apply(32'hCAFE,      32'h0,        5'd10, 8'h22, 0, 0, 1, 2'b11, 0, 0, 32'hCAFE, 5'd10, 1, 8'h22, 0);
    apply(32'h05,        32'h0,        5'd11, 8'h22, 1, 0, 1, 2'b00, 0, 0, 32'h05, 5'd11, 1, 8'h22, 0);
    // Stall + flush over a pending store: hold, no write.
    apply(32'h30,        32'h11112222, 5'd12, 8'h23, 0, 1, 1, 2'b00, 0, 0, 32'h30, 5'd12, 1, 8'h23, 0);
    apply(32'h30,        32'h00BADBAD, 5'd13, 8'h24, 0, 1, 1, 2'b00, 1, 1, 32'h30, 5'd12, 1, 8'h23, 0);
    apply(32'h30,        32'h00BADBAD, 5'd13, 8'h24, 0, 1, 1, 2'b00, 1, 1, 32'h30, 5'd12, 1, 8'h23, 0);
    // Flush alone yields a bubble carrying pcM; a store under flush still lands.
    apply(32'h44,        32'h0,        5'd14, 8'h25, 0, 0, 1, 2'b00, 0, 1, 32'h0, 5'd0, 0, 8'h25, 0);
    apply(32'h31,        32'h00005A5A, 5'd15, 8'h26, 1, 1, 1, 2'b01, 0, 1, 32'h0, 5'd0, 0, 8'h26, 0);
    apply(32'h30,        32'h0,        5'd15, 8'h27, 1, 0, 1, 2'b01, 0, 0, 32'h11112222, 5'd15, 1, 8'h27, 1);
    apply(32'h31,        32'h0,        5'd16, 8'h28, 1, 0, 1, 2'b01, 0, 0, 32'h00005A5A, 5'd16, 1, 8'h28, 1);
    // Simultaneous read and write returns the old word.
    apply(32'h10,        32'h0000000A, 5'd0,  8'h29, 0, 1, 0, 2'b00, 0, 0, 32'h10, 5'd0, 0, 8'h29, 0);
    apply(32'h10,        32'h0000000B, 5'd17, 8'h2A, 1, 1, 1, 2'b01, 0, 0, 32'h0000000A, 5'd17, 1, 8'h2A, 1);
    apply(32'h10,        32'h0,        5'd18, 8'h2B, 1, 0, 1, 2'b01, 0, 0, 32'h0000000B, 5'd18, 1, 8'h2B, 1);

    @(posedge clk); #3;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected responses never compared, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
